bp_nonsynth_watchdog_scheduler: RTL and testbench
=================================================

Name: bp_nonsynth_watchdog_scheduler

Overview:
- Collects halt and stall-fail events from the num_core_p per-core watchdogs of a multicore testbench.
- Round-robin arbitrates these events onto one shared report channel, which feeds the single print/finish agent.
- Sequences end of simulation through run, drain and done states.
- Non-synthesizable testbench infrastructure, instantiated once per top-level bench.

Parameters:
- num_core_p, 4, number of cores/watchdogs feeding the scheduler (>=1).
- drain_cycles_p, 1024, max cycles allowed in drain before forcing done with failure (>=1).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- halt_i  in  num_core_p  per-core halt-detected level; bit i may stay high indefinitely.
- fail_i  in  num_core_p  per-core stall/X-PC failure level.
- report_v_o  out  1  a report is presented.
- report_core_o  out  BSG_SAFE_CLOG2(num_core_p)  core id of the presented report.
- report_fail_o  out  1  1 = failure report, 0 = halt report.
- report_yumi_i  in  1  sink consumes the report this cycle; legal only when report_v_o=1.
- halted_mask_o  out  num_core_p  sticky mask of cores whose halt has been recorded.
- done_o  out  1  simulation may finish.
- fail_o  out  1  a failure or drain timeout occurred; sticky.

Behaviour:
- Reset (async assert, release sync to clk_i):
  - state=e_run.
  - All pending bits, halted_mask_o and fail_o = 0.
  - Round-robin pointer = 0; timeout counter = 0.
  - report_v_o=0, report_core_o=0, report_fail_o=0, done_o=0.
- Event capture, per core i, each event recorded at most once:
  - halt_pend[i] sets when halt_i[i]=1 and halted_mask[i]=0.
  - halted_mask[i] sets in the same cycle, so a held level never re-queues.
  - fail_pend[i] sets when fail_i[i]=1 and fail_seen[i]=0; fail_seen[i] sets in the same cycle.
  - Capture latency 1 cycle: earliest report_v_o is the cycle after the input rises.
  - Inputs are ignored once state=e_done.
- Arbitration:
  - If any fail_pend bit is set, the winner is the first set fail_pend bit scanning from the pointer upward with wrap.
  - Otherwise, the same scan is applied to halt_pend.
  - report_v_o = any pending bit set (registered-state function, no input-to-output combinational path).
  - The winner is held stable while report_v_o=1 and report_yumi_i=0, even if a higher-priority event arrives.
  - The winner is re-evaluated only after a yumi.
- Handshake:
  - On report_yumi_i=1, clear the winner's pending bit and set pointer = winner+1 (wraps to 0 after num_core_p-1).
  - Back-to-back yumi gives one report per cycle.
  - A consumed failure report sets fail_o.
  - report_yumi_i while report_v_o=0 is illegal and must be flagged by an assertion; state is unchanged.
- FSM:
  - e_run -> e_drain when halted_mask becomes all ones, or when any fail report is consumed.
  - e_drain:
    - The timeout counter increments each cycle and saturates at drain_cycles_p.
    - -> e_done when no bits are pending, evaluated after that cycle's yumi.
    - -> e_done when the counter reaches drain_cycles_p; this also sets fail_o.
  - e_done: terminal until reset; done_o=1 and report_v_o=0, with pending bits left unreported.
- Simultaneous events:
  - A capture and a yumi in the same cycle on different cores both take effect.
  - If the last halt and a fail on another core arrive together, the fail is reported first.
- Reset mid-operation: all state returns to the reset values immediately; there is no partial drain.
- num_core_p=1: report_core_o is tied to 0 and the pointer is unused.

Test Plan:
- num_core_p=4, no yumi stall: halt_i raised 4'b1111 in one cycle -> reports cores 0,1,2,3 in consecutive cycles, all with report_fail_o=0; then e_drain; done_o=1 the cycle after the last yumi; fail_o=0.
- Pointer fairness: halt core 2, consume it, then halt_i=4'b1011 -> report order 3, 0, 1.
- Priority: halt_i[0] and fail_i[3] rise in the same cycle -> core 3 with report_fail_o=1 first, then core 0; fail_o=1 after the first yumi; e_drain entered.
- Held level plus stability: halt_i[1] held high 50 cycles with report_yumi_i=0 for 10 cycles, and fail_i[2] rising mid-hold -> report_core_o stays 1 and report_fail_o stays 0 until the yumi; exactly one halt report for core 1.
- Drain timeout: drain_cycles_p=8, all cores halt, sink never yumis -> done_o=1 and fail_o=1 exactly 8 cycles after e_drain entry; report_v_o=0 afterwards.
- Async reset: assert reset_i mid-drain between clock edges -> all outputs read 0 before the next posedge; after release, a new halt on core 0 reports normally.

Source files
------------

// File: rtl/bp_nonsynth_watchdog_scheduler.sv
// Purpose: funnel per-core halt/fail watchdog events onto one round-robin report channel and sequence end of sim.
// Latency: an event is capturable 1 cycle after its input rises; one report per cycle under back-to-back yumi.
// Backpressure: the presented report is held stable until report_yumi_i; new events queue as pending bits.
module bp_nonsynth_watchdog_scheduler #(
  parameter int num_core_p     = 4,
  parameter int drain_cycles_p = 1024,
  localparam int core_w_lp     = (num_core_p > 1) ? $clog2(num_core_p) : 1,
  localparam int cnt_w_lp      = $clog2(drain_cycles_p + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [num_core_p-1:0] halt_i,
  input  logic [num_core_p-1:0] fail_i,
  output logic                  report_v_o,
  output logic [core_w_lp-1:0]  report_core_o,
  output logic                  report_fail_o,
  input  logic                  report_yumi_i,
  output logic [num_core_p-1:0] halted_mask_o,
  output logic                  done_o,
  output logic                  fail_o
);

  typedef enum logic [1:0] {e_run, e_drain, e_done} state_e;

  state_e                state_r, state_n;
  logic [num_core_p-1:0] halt_pend_r, fail_pend_r, halted_mask_r, fail_seen_r;
  logic [num_core_p-1:0] halt_pend_n, fail_pend_n;
  logic [num_core_p-1:0] halt_cap, fail_cap, halt_clr, fail_clr;
  logic [core_w_lp-1:0]  ptr_r, ptr_n, scan_core, win_core, lock_core_r;
  logic                  scan_fail, win_fail, lock_fail_r, lock_r;
  logic [cnt_w_lp-1:0]   cnt_r;
  logic                  fail_r, any_pend, fire, fire_fail;
  logic                  drain_empty, timeout_hit, timeout_fail;

  // Round-robin scan from the pointer; any pending failure outranks every halt.
  always_comb begin
    logic [num_core_p-1:0] src;
    int best_d;
    int d;
    scan_core = '0;
    scan_fail = |fail_pend_r;
    src       = scan_fail ? fail_pend_r : halt_pend_r;
    best_d    = num_core_p;
    d         = 0;
    for (int i = 0; i < num_core_p; i++) begin
      d = (i + num_core_p - int'(ptr_r)) % num_core_p;
      if (src[i] && (d < best_d)) begin
        best_d    = d;
        scan_core = core_w_lp'(i);
      end
    end
  end

  // A report left unconsumed stays locked so the sink sees a stable winner.
  assign win_core = lock_r ? lock_core_r : scan_core;
  assign win_fail = lock_r ? lock_fail_r : scan_fail;

  assign any_pend      = (|halt_pend_r) || (|fail_pend_r);
  assign report_v_o    = any_pend && (state_r != e_done);
  assign report_core_o = (report_v_o && (num_core_p > 1)) ? win_core : '0;
  assign report_fail_o = report_v_o & win_fail;
  assign fire          = report_v_o & report_yumi_i;
  assign fire_fail     = fire & win_fail;

  assign halted_mask_o = halted_mask_r;
  assign done_o        = (state_r == e_done);
  assign fail_o        = fail_r;

  // Capture each event once per core, clear the consumed winner, advance the pointer.
  always_comb begin
    halt_cap = '0;
    fail_cap = '0;
    halt_clr = '0;
    fail_clr = '0;
    ptr_n    = ptr_r;
    if (state_r != e_done) begin
      halt_cap = halt_i & ~halted_mask_r;
      fail_cap = fail_i & ~fail_seen_r;
    end
    for (int i = 0; i < num_core_p; i++) begin
      if (fire && (win_core == core_w_lp'(i))) begin
        if (win_fail) fail_clr[i] = 1'b1;
        else          halt_clr[i] = 1'b1;
      end
    end
    if (fire) begin
      ptr_n = (win_core == core_w_lp'(num_core_p - 1)) ? '0 : win_core + core_w_lp'(1);
    end
    halt_pend_n = (halt_pend_r | halt_cap) & ~halt_clr;
    fail_pend_n = (fail_pend_r | fail_cap) & ~fail_clr;
  end

  // Drain finishes cleanly when nothing remains; running out of cycles is a failure.
  assign drain_empty  = !(|halt_pend_n) && !(|fail_pend_n);
  assign timeout_hit  = (state_r == e_drain) && (cnt_r >= cnt_w_lp'(drain_cycles_p - 1));
  assign timeout_fail = timeout_hit && !drain_empty;

  // Next-state: run until every core halts or a failure is reported, then drain, then done.
  always_comb begin
    state_n = state_r;
    case (state_r)
      e_run: begin
        if ((&(halted_mask_r | halt_cap)) || fire_fail) state_n = e_drain;
      end
      e_drain: begin
        if (drain_empty || timeout_hit) state_n = e_done;
      end
      e_done:  state_n = e_done;
      default: state_n = e_run;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= e_run;
    else         state_r <= state_n;
  end

  // Pending/sticky bookkeeping, winner lock, drain counter and failure flag.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      halt_pend_r   <= '0;
      fail_pend_r   <= '0;
      halted_mask_r <= '0;
      fail_seen_r   <= '0;
      ptr_r         <= '0;
      lock_r        <= 1'b0;
      lock_core_r   <= '0;
      lock_fail_r   <= 1'b0;
      cnt_r         <= '0;
      fail_r        <= 1'b0;
    end else begin
      halt_pend_r   <= halt_pend_n;
      fail_pend_r   <= fail_pend_n;
      halted_mask_r <= halted_mask_r | halt_cap;
      fail_seen_r   <= fail_seen_r | fail_cap;
      ptr_r         <= ptr_n;
      lock_r        <= report_v_o & ~report_yumi_i;
      lock_core_r   <= win_core;
      lock_fail_r   <= win_fail;
      if ((state_r == e_drain) && (cnt_r != cnt_w_lp'(drain_cycles_p)))
        cnt_r <= cnt_r + cnt_w_lp'(1);
      if (fire_fail || timeout_fail)
        fail_r <= 1'b1;
    end
  end

  // Consuming when nothing is presented is a sink bug.
  assert property (@(posedge clk_i) disable iff (reset_i) (report_yumi_i |-> report_v_o));

endmodule

// File: tb/tb_bp_nonsynth_watchdog_scheduler.sv
// Purpose: self-checking bench for the watchdog scheduler: vector tables, corner sequences, random vs model.
// Latency: all checks sampled on the falling edge, inputs driven on the falling edge.
// Backpressure: yumi is only issued when a report is expected to be presented.
module tb_bp_nonsynth_watchdog_scheduler;
  localparam int N     = 4;
  localparam int DRAIN = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] halt_s = '0, fail_s = '0;
  logic       yumi_s = 1'b0;
  logic       report_v, report_fail, done, fail_flag;
  logic [1:0] report_core;
  logic [3:0] halted_mask;

  always #5 clk = ~clk;

  bp_nonsynth_watchdog_scheduler #(.num_core_p(N), .drain_cycles_p(DRAIN)) dut (
    .clk_i(clk), .reset_i(rst), .halt_i(halt_s), .fail_i(fail_s),
    .report_v_o(report_v), .report_core_o(report_core), .report_fail_o(report_fail),
    .report_yumi_i(yumi_s), .halted_mask_o(halted_mask), .done_o(done), .fail_o(fail_flag)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // {v, core[1:0], rfail, done, fail, mask[3:0]}
  function automatic logic [9:0] obs();
    return {report_v, report_core, report_fail, done, fail_flag, halted_mask};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; halt_s = '0; fail_s = '0; yumi_s = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst_before;
    logic [3:0] halt, fail;
    logic       yumi;
    logic       v;
    logic [1:0] core;
    logic       rf, dn, fo;
    logic [3:0] mask;
  } vec_t;
  vec_t vt[$];

  function automatic void add(logic r, logic [3:0] h, logic [3:0] f, logic y, logic v,
                              logic [1:0] c, logic rf, logic dn, logic fo, logic [3:0] m);
    vec_t e;
    e.rst_before = r; e.halt = h; e.fail = f; e.yumi = y;
    e.v = v; e.core = c; e.rf = rf; e.dn = dn; e.fo = fo; e.mask = m;
    vt.push_back(e);
  endfunction

  // ---------------- reference model ----------------
  bit [3:0] mh, mf, mmask, mseen;
  int       mptr, mst, mcnt, mcur;
  bit       mcurf, mfo;

  task automatic m_reset();
    mh = '0; mf = '0; mmask = '0; mseen = '0;
    mptr = 0; mst = 0; mcnt = 0; mcur = -1; mcurf = 0; mfo = 0;
  endtask

  function automatic int first_from_ptr(bit [3:0] src);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (mptr + k) % N;
      if (src[j]) return j;
    end
    return 0;
  endfunction

  task automatic m_outputs(output bit ev, output int ec, output bit ef);
    ev = (mst != 2) && ((mh != 0) || (mf != 0));
    ec = 0; ef = 0;
    if (ev) begin
      if (mcur >= 0) begin ec = mcur; ef = mcurf; end
      else if (mf != 0) begin ec = first_from_ptr(mf); ef = 1; end
      else begin ec = first_from_ptr(mh); ef = 0; end
    end
  endtask

  task automatic m_step(input logic [3:0] h, input logic [3:0] f, input logic y,
                        input bit ev, input int ec, input bit ef);
    bit consumed_fail;
    consumed_fail = 0;
    if (mst == 2) return;
    if (y && ev) begin
      if (ef) begin mf[ec] = 0; mfo = 1; consumed_fail = 1; end
      else mh[ec] = 0;
      mptr = (ec + 1) % N;
      mcur = -1;
    end else if (ev) begin
      mcur = ec; mcurf = ef;
    end
    for (int i = 0; i < N; i++) begin
      if (h[i] && !mmask[i]) begin mh[i] = 1; mmask[i] = 1; end
      if (f[i] && !mseen[i]) begin mf[i] = 1; mseen[i] = 1; end
    end
    if (mst == 0) begin
      if (mmask == 4'hF || consumed_fail) begin mst = 1; mcnt = 0; end
    end else begin
      mcnt++;
      if (mh == 0 && mf == 0) mst = 2;
      else if (mcnt >= DRAIN) begin mst = 2; mfo = 1; end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not end");
    $fatal(1);
  end

  initial begin
    logic [3:0] hl, fl;
    logic       y;
    bit         ev, ef;
    int         ec, n_h1;

    // all halt together, no stall
    add(1, 4'hF, 4'h0, 0, 0, 2'd0, 0, 0, 0, 4'h0);
    add(0, 4'hF, 4'h0, 1, 1, 2'd0, 0, 0, 0, 4'hF);
    add(0, 4'hF, 4'h0, 1, 1, 2'd1, 0, 0, 0, 4'hF);
    add(0, 4'hF, 4'h0, 1, 1, 2'd2, 0, 0, 0, 4'hF);
    add(0, 4'hF, 4'h0, 1, 1, 2'd3, 0, 0, 0, 4'hF);
    add(0, 4'hF, 4'h0, 0, 0, 2'd0, 0, 1, 0, 4'hF);
    // pointer fairness
    add(1, 4'h4, 4'h0, 0, 0, 2'd0, 0, 0, 0, 4'h0);
    add(0, 4'h4, 4'h0, 1, 1, 2'd2, 0, 0, 0, 4'h4);
    add(0, 4'hB, 4'h0, 0, 0, 2'd0, 0, 0, 0, 4'h4);
    add(0, 4'hB, 4'h0, 1, 1, 2'd3, 0, 0, 0, 4'hF);
    add(0, 4'hB, 4'h0, 1, 1, 2'd0, 0, 0, 0, 4'hF);
    add(0, 4'hB, 4'h0, 1, 1, 2'd1, 0, 0, 0, 4'hF);
    add(0, 4'hB, 4'h0, 0, 0, 2'd0, 0, 1, 0, 4'hF);
    // fail outranks simultaneous halt
    add(1, 4'h1, 4'h8, 0, 0, 2'd0, 0, 0, 0, 4'h0);
    add(0, 4'h1, 4'h8, 1, 1, 2'd3, 1, 0, 0, 4'h1);
    add(0, 4'h1, 4'h8, 1, 1, 2'd0, 0, 0, 1, 4'h1);
    add(0, 4'h1, 4'h8, 0, 0, 2'd0, 0, 1, 1, 4'h1);

    foreach (vt[i]) begin
      if (vt[i].rst_before) do_reset();
      @(negedge clk);
      halt_s = vt[i].halt; fail_s = vt[i].fail; yumi_s = vt[i].yumi;
      chk($sformatf("vec%0d", i), obs(),
          {vt[i].v, vt[i].core, vt[i].rf, vt[i].dn, vt[i].fo, vt[i].mask});
      @(posedge clk);
    end

    // held halt level, stalled sink, fail arriving mid-stall
    do_reset();
    n_h1 = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      halt_s = 4'h2;
      fail_s = (c >= 5) ? 4'h4 : 4'h0;
      yumi_s = report_v && (c >= 11);
      if (c >= 1 && c <= 11)
        chk($sformatf("hold_c%0d", c), {report_v, report_core, report_fail}, {1'b1, 2'd1, 1'b0});
      if (yumi_s && report_core == 2'd1 && !report_fail) n_h1++;
      @(posedge clk);
    end
    @(negedge clk);
    yumi_s = 1'b0;
    chk("hold_core1_reports", n_h1, 1);
    chk("hold_end_done_fail", {done, fail_flag, report_v}, {1'b1, 1'b1, 1'b0});

    // drain timeout with a sink that never consumes
    do_reset();
    @(negedge clk);
    halt_s = 4'hF; yumi_s = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= DRAIN; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("drain_k%0d", k), {done, fail_flag}, (k == DRAIN) ? 2'b11 : 2'b00);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("drain_after_v", {report_v, done}, 2'b01);
    end

    // asynchronous reset in the middle of drain
    do_reset();
    @(negedge clk);
    halt_s = 4'hF;
    @(posedge clk);
    @(posedge clk);
    #2 chk("pre_async_rst", obs(), {1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 4'hF});
    #1 rst = 1'b1; halt_s = 4'h0;
    #1 chk("async_rst_outputs", obs(), 10'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    halt_s = 4'h1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_report", obs(), {1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 4'h1});
    yumi_s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    yumi_s = 1'b0;
    chk("post_rst_idle", obs(), {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'h1});

    // randomized episodes against the reference model
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      m_reset();
      hl = '0; fl = '0;
      for (int c = 0; c < 120; c++) begin
        @(negedge clk);
        if ($urandom_range(0, 9) == 0)  hl[$urandom_range(0, 3)] = 1'b1;
        if ($urandom_range(0, 9) == 0)  hl[$urandom_range(0, 3)] = 1'b0;
        if ($urandom_range(0, 39) == 0) fl[$urandom_range(0, 3)] = 1'b1;
        if ($urandom_range(0, 9) == 0)  fl[$urandom_range(0, 3)] = 1'b0;
        m_outputs(ev, ec, ef);
        y = ev && ($urandom_range(0, 3) != 0);
        halt_s = hl; fail_s = fl; yumi_s = y;
        chk($sformatf("rand_ep%0d_c%0d", ep, c), obs(),
            {ev, 2'(ec), ef, (mst == 2), mfo, mmask});
        @(posedge clk);
        m_step(hl, fl, y, ev, ec, ef);
      end
    end

    @(negedge clk);
    yumi_s = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
